// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 32-bit ALU; result lands in a one-entry response slot one cycle after accept.
// A full slot blocks both requesters until it drains; drain and accept in the same cycle sustain one op per cycle.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic [3:0]  alu_flags
);
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        arith;
  logic        ovf;

  always_comb begin
    // Odd codes subtract: a + ~b + 1, so C is the ARM-style "no borrow".
    b_eff  = alu_control[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'b0, alu_control[0]};
    arith  = (alu_control[2:1] == 2'b00);
    ovf    = (a[31] ~^ b_eff[31]) & (a[31] ^ sum[31]);
    result = '0;
    case (alu_control)
      3'b000, 3'b001: result = sum[31:0];
      3'b010:         result = a & b;
      3'b011:         result = a | b;
      3'b100:         result = a ^ b;
      3'b101:         result = {31'b0, sum[31] ^ ovf};
      default:        result = '0;
    endcase
    alu_flags = {result[31], (result == 32'b0), arith & sum[32], arith & ovf};
  end
endmodule

module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  op0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  op1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1
);
  typedef enum logic {EMPTY, FULL} slot_state_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
  } rsp_t;

  slot_state_t state_q, state_d;
  rsp_t        rsp_q;
  logic        last_gnt;
  logic        slot_free;
  logic        gnt0, gnt1;
  logic        accept;
  logic        sel_id;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic [3:0]  alu_flags;

  assign slot_free = !reset && (state_q == EMPTY || rsp_ready);

  // Requester 1 wins contention only in round-robin mode when 0 was served last.
  assign gnt1 = req_valid1 && (!req_valid0 || (RR && !last_gnt));
  assign gnt0 = req_valid0 && !gnt1;

  assign req_ready0 = slot_free && gnt0;
  assign req_ready1 = slot_free && gnt1;
  assign accept     = req_ready0 || req_ready1;
  assign sel_id     = gnt1;

  assign alu_a  = sel_id ? a1  : a0;
  assign alu_b  = sel_id ? b1  : b0;
  assign alu_op = sel_id ? op1 : op0;

  alu u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_op),
    .result      (alu_result),
    .alu_flags   (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      rsp_q    <= '0;
      last_gnt <= 1'b1;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_q    <= '{id: sel_id, result: alu_result, flags: alu_flags};
        last_gnt <= sel_id;
        if (sel_id) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        else        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;
  assign rsp_flags  = rsp_q.flags;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter share stimulus; each is checked against hand-computed values.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid0, req_valid1, rsp_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [2:0]  op0, op1;

  logic        rr_ready0, rr_ready1, rr_valid, rr_id;
  logic [31:0] rr_result;
  logic [3:0]  rr_flags;
  logic [15:0] rr_cnt0, rr_cnt1;

  logic        fp_ready0, fp_ready1, fp_valid, fp_id;
  logic [31:0] fp_result;
  logic [3:0]  fp_flags;
  logic [15:0] fp_cnt0, fp_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(rr_ready0), .req_ready1(rr_ready1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .rsp_valid(rr_valid), .rsp_ready(rsp_ready), .rsp_id(rr_id),
    .rsp_result(rr_result), .rsp_flags(rr_flags),
    .gnt_cnt0(rr_cnt0), .gnt_cnt1(rr_cnt1)
  );

  alu_arbiter #(.RR(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(fp_ready0), .req_ready1(fp_ready1),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .rsp_valid(fp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_id),
    .rsp_result(fp_result), .rsp_flags(fp_flags),
    .gnt_cnt0(fp_cnt0), .gnt_cnt1(fp_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    tick();
    tick();
    // Ready must stay low while reset is high.
    req_valid0 = 1'b1;
    #1;
    chk("ready0_in_reset", rr_ready0, 0);
    tick();
    req_valid0 = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_valid", rr_valid, 0);
    chk("reset_id", rr_id, 0);
    chk("reset_result", rr_result, 0);
    chk("reset_flags", rr_flags, 0);
    chk("reset_cnt0", rr_cnt0, 0);
    chk("reset_cnt1", rr_cnt1, 0);

    // Single add overflowing into the sign bit.
    req_valid0 = 1'b1; a0 = 32'h7FFF_FFFF; b0 = 32'h1; op0 = 3'b000;
    #1;
    chk("add_ready0", rr_ready0, 1);
    chk("add_ready1", rr_ready1, 0);
    tick();
    req_valid0 = 1'b0;
    chk("add_valid", rr_valid, 1);
    chk("add_id", rr_id, 0);
    chk("add_result", rr_result, 32'h8000_0000);
    chk("add_flags", rr_flags, 4'b1001);
    chk("add_cnt0", rr_cnt0, 1);

    // Single subtract giving zero.
    req_valid1 = 1'b1; a1 = 32'd5; b1 = 32'd5; op1 = 3'b001;
    #1;
    chk("sub_ready1", rr_ready1, 1);
    tick();
    req_valid1 = 1'b0;
    chk("sub_valid", rr_valid, 1);
    chk("sub_id", rr_id, 1);
    chk("sub_result", rr_result, 0);
    chk("sub_flags", rr_flags, 4'b0110);
    chk("sub_cnt1", rr_cnt1, 1);
    tick();
    chk("drain_valid", rr_valid, 0);

    // Contention: requester 0 adds 100+1, requester 1 subtracts 200-50.
    do_reset();
    req_valid0 = 1'b1; a0 = 32'd100; b0 = 32'd1;  op0 = 3'b000;
    req_valid1 = 1'b1; a1 = 32'd200; b1 = 32'd50; op1 = 3'b001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready0", rr_ready0, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", rr_ready1, (i % 2 == 1) ? 1 : 0);
      chk("fp_ready1", fp_ready1, 0);
      tick();
      chk("rr_seq_valid", rr_valid, 1);
      chk("rr_seq_id", rr_id, i % 2);
      chk("rr_seq_result", rr_result, (i % 2 == 0) ? 32'd101 : 32'd150);
      chk("fp_seq_id", fp_id, 0);
      chk("fp_seq_result", fp_result, 32'd101);
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    chk("rr_cnt0_after", rr_cnt0, 3);
    chk("rr_cnt1_after", rr_cnt1, 3);
    chk("fp_cnt0_after", fp_cnt0, 6);
    chk("fp_cnt1_after", fp_cnt1, 0);
    tick();
    chk("contention_drain", rr_valid, 0);

    // Backpressure: 3|0xC held in the slot while requester 1 waits with 9-4.
    rsp_ready = 1'b0;
    req_valid0 = 1'b1; a0 = 32'h3; b0 = 32'hC; op0 = 3'b011;
    #1;
    chk("bp_ready0_empty", rr_ready0, 1);
    tick();
    req_valid0 = 1'b0;
    req_valid1 = 1'b1; a1 = 32'd9; b1 = 32'd4; op1 = 3'b001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready0", rr_ready0, 0);
      chk("bp_ready1", rr_ready1, 0);
      chk("bp_valid", rr_valid, 1);
      chk("bp_id", rr_id, 0);
      chk("bp_result", rr_result, 32'hF);
      chk("bp_flags", rr_flags, 4'b0000);
      chk("bp_cnt0", rr_cnt0, 4);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready1", rr_ready1, 1);
    tick();
    req_valid1 = 1'b0;
    chk("bp_reload_valid", rr_valid, 1);
    chk("bp_reload_id", rr_id, 1);
    chk("bp_reload_result", rr_result, 32'd5);
    chk("bp_reload_flags", rr_flags, 4'b0010);
    chk("bp_cnt1", rr_cnt1, 4);

    // Reset while full and stalled.
    rsp_ready = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst_ready0", rr_ready0, 0);
    tick();
    chk("rst_valid", rr_valid, 0);
    chk("rst_cnt0", rr_cnt0, 0);
    chk("rst_cnt1", rr_cnt1, 0);
    chk("rst_result", rr_result, 0);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready0", rr_ready0, 1);
    chk("post_rst_ready1", rr_ready1, 0);
    tick();
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    chk("post_rst_id", rr_id, 0);

    // Counter wrap on requester 0.
    do_reset();
    req_valid0 = 1'b1; a0 = 32'd1; b0 = 32'd2; op0 = 3'b000;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_cnt0_max", rr_cnt0, 16'hFFFF);
    tick();
    chk("wrap_cnt0_zero", rr_cnt0, 0);
    chk("wrap_cnt1", rr_cnt1, 0);
    chk("wrap_fp_cnt0_zero", fp_cnt0, 0);
    chk("wrap_result", rr_result, 32'd3);
    req_valid0 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit ALU (`alu`: a, b, ALUControl[2:0] -> Result[31:0], ALUFlags[3:0] = {N,Z,C,V}) between two requesters. Each requester issues operations through a valid/ready handshake. The arbiter picks one winner per cycle, round-robin or fixed priority, and drives that operation through one internal `alu` instance. The result and flags are registered into a single-entry response buffer tagged with the winner's id, and the buffer supports backpressure. The block sits between the execute-stage issue logic and the ALU, and lets a second client (address generation or the self-test sequencer) use the ALU without a second copy.

## Interface
- `RR`, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid0` / `req_valid1`  in  1  requester i presents an operation.
- `req_ready0` / `req_ready1`  out  1  requester i's operation is accepted this cycle.
- `a0`, `b0` / `a1`, `b1`  in  32  operands of requester i.
- `op0` / `op1`  in  3  ALUControl code of requester i, passed to `alu` unchanged.
- `rsp_valid`  out  1  response buffer holds a result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  1  requester that issued the buffered operation.
- `rsp_result`  out  32  registered ALU Result.
- `rsp_flags`  out  4  registered ALUFlags {N,Z,C,V}.
- `gnt_cnt0` / `gnt_cnt1`  out  16  number of grants given to requester i; wraps from 0xFFFF to 0.

## Operation
- **Slot state.** Two-state buffer FSM.
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- **slot_free.** slot_free = EMPTY, or (FULL and `rsp_ready`).
- **Arbitration.** Combinational; requires slot_free.
  - Only one `req_valid` high: that requester is granted.
  - Both high, `RR`=1: the requester not granted most recently wins.
  - Both high, `RR`=0: requester 0 always wins.
  - Neither high: no grant.
- **Ready.** `req_ready`i = slot_free & grant_i. At most one `req_ready` is high per cycle. `req_ready` may depend combinationally on both `req_valid` inputs and on `rsp_ready`.
- **ALU drive.** A mux selects the winner's a/b/op into the single `alu` instance. With no grant, the mux holds the requester-0 inputs. Outputs are unaffected because the buffer is not loaded.
- **Accept (`req_valid`i & `req_ready`i).**
  - At the clock edge, load the buffer with `rsp_result`=Result, `rsp_flags`=ALUFlags, `rsp_id`=i. State goes to FULL.
  - Update `last_gnt` to i.
  - Increment `gnt_cnt`i.
- **Drain.** `rsp_valid` & `rsp_ready` with no accept in the same cycle: state goes to EMPTY. Data registers hold their stale values.
- **Simultaneous drain and accept.** The buffer reloads with the new operation and stays FULL, giving back-to-back throughput of 1 operation per cycle.
- **Requester protocol.** A requester must hold `req_valid` and its payload stable until accepted. The arbiter does not re-sample a dropped request.
- **Reset.** A pending response is discarded.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - `gnt_cnt0`=`gnt_cnt1`=0.
  - `last_gnt`=1, so requester 0 wins the first contention.
  - `req_ready` outputs are 0 while `reset` is high.
- **Arithmetic.** Entirely the ALU's; no width change. Flags are captured exactly as `alu` produces them for the selected op.

## Timing
- Latency: an operation accepted at edge N has `rsp_valid`=1 with its data from cycle N+1. It remains until the `rsp_ready` edge.
- `rsp_*` outputs are fully registered; no combinational path from requester inputs to `rsp_*`.
- Combinational paths: `req_valid0`/`req_valid1`/`rsp_ready` -> `req_ready0`/`req_ready1`.
- While FULL and `rsp_ready`=0: both `req_ready` are 0, and `rsp_*` and the counters hold.
- With reset asserted during FULL, the next edge gives `rsp_valid`=0 regardless of `rsp_ready`.
- Round-robin fairness: with both requesters continuously valid and `rsp_ready`=1, grants alternate 0,1,0,1,… starting with 0 after reset.

## Test plan
- **Single add.** Reset, then requester 0 issues a=0x7FFFFFFF, b=0x00000001, op=000 (add). Required: `req_ready0`=1 that cycle. Next cycle: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0x80000000, `rsp_flags`=1001. `gnt_cnt0`=1.
- **Single subtract.** Requester 1 issues a=b=0x00000005, op=001 (sub). Required: `rsp_result`=0x00000000, `rsp_flags`=0110, `rsp_id`=1.
- **Contention, `RR`=1.** Both requesters valid continuously for 6 cycles with `rsp_ready`=1. Required: `rsp_id` sequence 0,1,0,1,0,1; `gnt_cnt0`=`gnt_cnt1`=3; one response per cycle. Repeat with `RR`=0: all six grants go to 0, and `req_ready1` stays 0.
- **Backpressure.** Hold `rsp_ready`=0 for 4 cycles after one accept. Required: both `req_ready`=0; `rsp_result`/`rsp_flags`/`rsp_id` stable. When `rsp_ready` rises with a pending request, drain and accept occur in the same cycle and `rsp_valid` stays 1.
- **Reset mid-operation.** Assert `reset` while FULL with `rsp_ready`=0. Required: next cycle `rsp_valid`=0, counters 0; the first post-reset contention is granted to requester 0.
- **Counter wrap.** Issue 65536 requests from requester 0. Required: `gnt_cnt0` goes 0xFFFF -> 0x0000; `gnt_cnt1` is unchanged.
